data_sram_responder: RTL

Memory-side responder for the CPU data port. It accepts load and store requests from the execute stage over a req/addr_ok/data_ok handshake and writes store data with byte strobes. It returns load data in order after a fixed latency, which the memory stage then aligns and extends. It is the data-RAM model for SoC-less simulation and the reference responder for verifying the core's data-port initiator.

---
 rtl/data_sram_responder_pkg.sv | 19 +
 rtl/data_sram_responder_resp_fifo.sv | 68 ++++++
 rtl/data_sram_responder.sv | 83 ++++++++
 3 files changed

// File: rtl/data_sram_responder_pkg.sv
// Shared definitions for the data-port SRAM responder: access size codes,
// the response FIFO entry layout and the parameter range limits.
package data_sram_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int MAX_LATENCY     = 4;
    localparam int MAX_OUTSTANDING = 4;

    // cnt is wide enough for the largest initial countdown, MAX_LATENCY-1
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [1:0]  cnt;
    } resp_entry_t;

endpackage

// File: rtl/data_sram_responder_resp_fifo.sv
// In-order response FIFO. Each entry carries its data and a countdown set
// to LATENCY-1 when pushed; the head is due once its countdown reaches zero.
// Entries behind the head keep counting down, so back-to-back accepts come
// out on back-to-back cycles.
module resp_fifo
    import data_sram_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [31:0]                  push_data,
    input  logic                         pop,
    output logic                         head_due,
    output logic [31:0]                  head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int         COUNT_W  = $clog2(DEPTH + 1);
    localparam int         PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [1:0] LOAD_CNT = 2'(LATENCY - 1);

    resp_entry_t      entries [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap modulo DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head_due  = entries[rd_ptr].valid && (entries[rd_ptr].cnt == 2'd0);
    assign head_data = entries[rd_ptr].data;

    // Countdown, pop and push; a push into the slot popped on the same edge wins
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries[i].valid && (entries[i].cnt != 2'd0)) begin
                    entries[i].cnt <= entries[i].cnt - 2'd1;
                end
            end
            if (pop) begin
                entries[rd_ptr].valid <= 1'b0;
                rd_ptr                <= bump(rd_ptr);
            end
            if (push) begin
                entries[wr_ptr] <= '{valid: 1'b1, data: push_data, cnt: LOAD_CNT};
                wr_ptr          <= bump(wr_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-RAM responder for the CPU data port. Accepts loads and stores over a
// req/addr_ok handshake, merges store bytes under wstrb, and returns one
// response per accepted request, in order, exactly LATENCY cycles later.
module data_sram_responder
    import data_sram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1,
    parameter int MAX_OUT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic        addr_stall,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int COUNT_W = $clog2(MAX_OUT + 1);

    if ((LATENCY < 1) || (LATENCY > MAX_LATENCY)) begin : g_bad_latency
        $error("data_sram_responder: LATENCY must be 1..%0d", MAX_LATENCY);
    end
    if ((MAX_OUT < 1) || (MAX_OUT > MAX_OUTSTANDING)) begin : g_bad_max_out
        $error("data_sram_responder: MAX_OUT must be 1..%0d", MAX_OUTSTANDING);
    end

    logic [31:0]           mem [0:(1 << ADDR_WIDTH) - 1];
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  accept;
    logic                  head_due;
    logic [31:0]           head_data;
    logic [31:0]           push_data;
    logic [COUNT_W-1:0]    count;
    logic                  unused_ok;

    // Upper address bits alias and the byte offset is the initiator's concern;
    // size is carried for debug visibility only.
    assign word_idx  = addr[ADDR_WIDTH+1:2];
    assign unused_ok = ^{size, addr[31:ADDR_WIDTH+2], addr[1:0]};

    // A slot freed by this cycle's response can be refilled in the same cycle
    assign data_ok = head_due && !reset;
    assign addr_ok = !reset && !addr_stall && ((count < COUNT_W'(MAX_OUT)) || data_ok);
    assign accept  = req && addr_ok;
    assign rdata   = data_ok ? head_data : 32'd0;

    // Loads capture the word before any write at this edge; a store and a
    // load can never be accepted on the same edge, so there is no conflict.
    assign push_data = wr ? 32'd0 : mem[word_idx];

    // Byte-strobed store into the RAM; contents survive reset
    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    resp_fifo #(
        .DEPTH   (MAX_OUT),
        .LATENCY (LATENCY)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (push_data),
        .pop       (data_ok),
        .head_due  (head_due),
        .head_data (head_data),
        .count     (count)
    );

endmodule
